// File: rtl/and_gate_cell.sv
// and_gate_cell: bitwise two-input AND leaf cell.
// Provides a zero-latency combinational result plus registered copies,
// registered reduction flags and a saturating all-ones cycle counter.
module and_gate_cell #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     out,
    output logic [WIDTH-1:0]     out_q,
    output logic                 any_q,
    output logic                 all_q,
    output logic [CNT_WIDTH-1:0] all_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic and_any;
    logic and_all;
    logic cnt_at_max;

    // Zero-latency result; independent of clk and rst so it is valid in reset.
    assign out = a & b;

    // Reductions of the live result feed the registered flags and counter.
    assign and_any    = |out;
    assign and_all    = &out;
    assign cnt_at_max = (all_cnt == CNT_MAX);

    // Registered result and flags; synchronous reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            any_q <= 1'b0;
            all_q <= 1'b0;
        end else begin
            out_q <= out;
            any_q <= and_any;
            all_q <= and_all;
        end
    end

    // All-ones cycle counter; holds at its maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            all_cnt <= '0;
        end else if (and_all && !cnt_at_max) begin
            all_cnt <= all_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_and_gate_cell.sv
// Directed self-checking bench for and_gate_cell.
// Three instances: WIDTH=1 on a manually pulsed clock, WIDTH=8 with the
// default counter, and WIDTH=8 with a 2-bit counter for saturation.
module tb_and_gate_cell;

    int checks = 0;
    int errors = 0;

    // Free-running clock for the 8-bit instances.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance, clock pulsed by hand.
    logic       clk1 = 1'b0;
    logic       rst1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [0:0] out1, out_q1;
    logic       any_q1, all_q1;
    logic [15:0] cnt1;

    // WIDTH=8, CNT_WIDTH=16 instance.
    logic       rst8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] out8, out_q8;
    logic       any_q8, all_q8;
    logic [15:0] cnt8;

    // WIDTH=8, CNT_WIDTH=2 instance.
    logic       rsts = 1'b1;
    logic [7:0] as = '0, bs = '0;
    logic [7:0] outs, out_qs;
    logic       any_qs, all_qs;
    logic [1:0] cnts;

    and_gate_cell #(.WIDTH(1), .CNT_WIDTH(16)) u_w1 (
        .clk(clk1), .rst(rst1), .a(a1), .b(b1),
        .out(out1), .out_q(out_q1), .any_q(any_q1), .all_q(all_q1), .all_cnt(cnt1)
    );

    and_gate_cell #(.WIDTH(8), .CNT_WIDTH(16)) u_w8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8),
        .out(out8), .out_q(out_q8), .any_q(any_q8), .all_q(all_q8), .all_cnt(cnt8)
    );

    and_gate_cell #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rsts), .a(as), .b(bs),
        .out(outs), .out_q(out_qs), .any_q(any_qs), .all_q(all_qs), .all_cnt(cnts)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge of clk and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single rising/falling pulse on the WIDTH=1 clock.
    task automatic pulse1();
        #5 clk1 = 1'b1;
        #5 clk1 = 1'b0;
        #1;
    endtask

    logic [7:0] x8;

    initial begin
        // Combinational truth table, WIDTH=1, no clock activity.
        a1 = 1'b0; b1 = 1'b0; #5; check("w1_tt_00", out1, 1'b0);
        a1 = 1'b0; b1 = 1'b1; #5; check("w1_tt_01", out1, 1'b0);
        a1 = 1'b1; b1 = 1'b0; #5; check("w1_tt_10", out1, 1'b0);
        a1 = 1'b1; b1 = 1'b1; #5; check("w1_tt_11", out1, 1'b1);

        // WIDTH=1 registered path: any_q and all_q track out_q.
        rst1 = 1'b1; pulse1();
        check("w1_rst_out_q", out_q1, 1'b0);
        check("w1_rst_any_q", any_q1, 1'b0);
        rst1 = 1'b0; pulse1();
        check("w1_out_q_1", out_q1, 1'b1);
        check("w1_any_q_1", any_q1, 1'b1);
        check("w1_all_q_1", all_q1, 1'b1);
        check("w1_cnt_1",   cnt1,   16'd1);
        a1 = 1'b0; pulse1();
        check("w1_out_q_0", out_q1, 1'b0);
        check("w1_any_q_0", any_q1, 1'b0);
        check("w1_all_q_0", all_q1, 1'b0);
        check("w1_cnt_hold", cnt1,  16'd1);

        // Reset edge for both 8-bit instances.
        a8 = 8'hF0; b8 = 8'h3C;
        tick();
        check("w8_rst_out_q", out_q8, 8'h00);
        check("w8_rst_any_q", any_q8, 1'b0);
        check("w8_rst_all_q", all_q8, 1'b0);
        check("w8_rst_cnt",   cnt8,   16'd0);
        check("w8_out_in_rst", out8,  8'h30);
        check("sat_rst_cnt",  cnts,   2'd0);
        rst8 = 1'b0; rsts = 1'b0;

        // Registered path with a mixed pattern.
        tick();
        check("w8_out_q_30", out_q8, 8'h30);
        check("w8_any_q_30", any_q8, 1'b1);
        check("w8_all_q_30", all_q8, 1'b0);
        check("w8_cnt_30",   cnt8,   16'd0);

        // Unsanitized X: masked by zero, propagated by ones.
        x8 = 8'hxx;
        a8 = x8; b8 = 8'h00; #1; check("w8_x_and_0", out8, 8'h00);
        b8 = 8'hFF;          #1; check("w8_x_and_1", out8, 8'hxx);

        // All ones.
        a8 = 8'hFF; b8 = 8'hFF;
        tick();
        check("w8_all_q_ff", all_q8, 1'b1);
        check("w8_out_q_ff", out_q8, 8'hFF);
        check("w8_cnt_ff",   cnt8,   16'd1);

        // Reset held for three edges with all-ones inputs.
        rst8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("w8_hold_rst_out_q_%0d", i), out_q8, 8'h00);
            check($sformatf("w8_hold_rst_cnt_%0d", i),   cnt8,   16'd0);
            check($sformatf("w8_hold_rst_out_%0d", i),   out8,   8'hFF);
        end

        // Release and count up to 5.
        rst8 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("w8_count_%0d", i), cnt8, 16'(i));
        end

        // Reset for one edge mid-count, then resume from 1.
        rst8 = 1'b1;
        tick();
        check("w8_midrst_cnt",   cnt8,   16'd0);
        check("w8_midrst_all_q", all_q8, 1'b0);
        rst8 = 1'b0;
        tick();
        check("w8_resume_cnt", cnt8, 16'd1);

        // Zero operand for four edges: counter unchanged.
        a8 = 8'h00; b8 = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("w8_zero_any_q_%0d", i), any_q8, 1'b0);
            check($sformatf("w8_zero_all_q_%0d", i), all_q8, 1'b0);
            check($sformatf("w8_zero_cnt_%0d", i),   cnt8,   16'd1);
        end

        // Single shared bit: any without all.
        a8 = 8'h81; b8 = 8'h01;
        tick();
        check("w8_lsb_out_q", out_q8, 8'h01);
        check("w8_lsb_any_q", any_q8, 1'b1);
        check("w8_lsb_all_q", all_q8, 1'b0);

        // Saturation with a 2-bit counter: 1, 2, 3, 3, 3, 3.
        as = 8'hFF; bs = 8'hFF;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("sat_cnt_%0d", i), cnts, (i < 3) ? 2'(i) : 2'd3);
        end
        check("sat_all_q", all_qs, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
